// File: rtl/cam_capture_if.sv
// Bundles the camera byte stream, the frame-buffer write port and the
// control/status lines of cam_capture_ctrl so they travel as one port.
//
// Handshake: regwrite is a valid-only strobe. addr_in/data_in are
// meaningful only in the cycle regwrite=1, and there is no ready
// (the buffer accepts a write every cycle). The camera side has no
// back-pressure either: href qualifies px_data on every rising clk edge.
interface cam_capture_if #(
  parameter int AW = 15,
  parameter int DW = 12
);
  logic          start;
  logic          cont;
  logic          vsync;
  logic          href;
  logic [7:0]    px_data;
  logic [AW-1:0] addr_in;
  logic [DW-1:0] data_in;
  logic          regwrite;
  logic          frame_done;
  logic          busy;
  logic          line_err;
  logic          ovf;
  logic [2:0]    state_dbg;

  // Side that drives the camera/control inputs (camera model, host)
  modport master (
    output start, cont, vsync, href, px_data,
    input  addr_in, data_in, regwrite, frame_done, busy, line_err, ovf,
           state_dbg
  );

  // The capture controller itself
  modport slave (
    input  start, cont, vsync, href, px_data,
    output addr_in, data_in, regwrite, frame_done, busy, line_err, ovf,
           state_dbg
  );
endinterface

// File: rtl/cam_capture_ctrl.sv
// Write-side controller for the frame buffer: pairs camera bytes into
// RGB444 pixels and writes them at row*IMA_W+col. Writes outside the
// IMA_W x IMA_H window are suppressed, so the reserved black address
// IMA_W*IMA_H is never touched. All outputs are registered.
module cam_capture_ctrl #(
  parameter int AW    = 15,
  parameter int DW    = 12,
  parameter int IMA_W = 160,
  parameter int IMA_H = 120
) (
  input logic          clk,
  input logic          reset,
  cam_capture_if.slave cam
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_VS_HI = 3'd1,
    WAIT_VS_LO = 3'd2,
    CAPTURE    = 3'd3,
    DONE       = 3'd4
  } state_t;

  localparam logic [AW-1:0] W_LIM   = AW'(IMA_W);
  localparam logic [AW-1:0] H_LIM   = AW'(IMA_H);
  localparam logic [AW-1:0] CNT_MAX = {AW{1'b1}};

  state_t        state_q, state_d;
  logic [AW-1:0] col_q;
  logic [AW-1:0] row_q;
  logic [AW-1:0] row_base_q;  // row_q*IMA_W kept incrementally, no multiplier
  logic          phase_q;
  logic [3:0]    red_q;
  logic          href_d_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] data_q;
  logic          regwrite_q;
  logic          frame_done_q;
  logic          busy_q;
  logic          line_err_q;
  logic          ovf_q;

  logic frame_start;
  logic cap_active;
  logic in_bounds;

  // Counters reset when leaving WAIT_VS_LO; pixel work only while vsync is
  // low in CAPTURE, so a byte coinciding with vsync rising is dropped.
  assign frame_start = (state_q == WAIT_VS_LO) && !cam.vsync;
  assign cap_active  = (state_q == CAPTURE) && !cam.vsync;
  assign in_bounds   = (col_q < W_LIM) && (row_q < H_LIM);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; continuous mode re-enters WAIT_VS_LO because vsync
  // is already high when DONE is reached
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:       if (cam.start)  state_d = WAIT_VS_HI;
      WAIT_VS_HI: if (cam.vsync)  state_d = WAIT_VS_LO;
      WAIT_VS_LO: if (!cam.vsync) state_d = CAPTURE;
      CAPTURE:    if (cam.vsync)  state_d = DONE;
      DONE:       state_d = cam.cont ? WAIT_VS_LO : IDLE;
      default:    state_d = IDLE;
    endcase
  end

  // Pixel assembly, write generation, line/row tracking and status flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_q        <= '0;
      row_q        <= '0;
      row_base_q   <= '0;
      phase_q      <= 1'b0;
      red_q        <= '0;
      href_d_q     <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      regwrite_q   <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
      line_err_q   <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      regwrite_q   <= 1'b0;
      frame_done_q <= (state_d == DONE);
      busy_q       <= (state_d != IDLE);
      if (frame_start) begin
        col_q      <= '0;
        row_q      <= '0;
        row_base_q <= '0;
        phase_q    <= 1'b0;
        href_d_q   <= 1'b0;
        line_err_q <= 1'b0;
        ovf_q      <= 1'b0;
      end else if (cap_active) begin
        href_d_q <= cam.href;
        if (cam.href) begin
          if (!phase_q) begin
            red_q   <= cam.px_data[3:0];
            phase_q <= 1'b1;
          end else begin
            phase_q <= 1'b0;
            if (in_bounds) begin
              regwrite_q <= 1'b1;
              data_q     <= {red_q, cam.px_data};
              addr_q     <= row_base_q + col_q;
            end else if (row_q >= H_LIM) begin
              ovf_q <= 1'b1;
            end
            if (col_q != CNT_MAX) col_q <= col_q + 1'b1;
          end
        end else begin
          // Between lines phase stays 0, so an odd trailing byte is lost
          phase_q <= 1'b0;
          if (href_d_q) begin
            if (col_q != W_LIM) line_err_q <= 1'b1;
            col_q      <= '0;
            if (row_q != CNT_MAX) row_q <= row_q + 1'b1;
            row_base_q <= row_base_q + W_LIM;
          end
        end
      end
    end
  end

  assign cam.addr_in    = addr_q;
  assign cam.data_in    = data_q;
  assign cam.regwrite   = regwrite_q;
  assign cam.frame_done = frame_done_q;
  assign cam.busy       = busy_q;
  assign cam.line_err   = line_err_q;
  assign cam.ovf        = ovf_q;
  assign cam.state_dbg  = state_q;

endmodule

// File: tb/tb_cam_capture_ctrl.sv
// Bench for cam_capture_ctrl: a per-cycle vector table for frame arming and
// first-pixel latency, plus hand-written frames for full capture, long/odd
// lines, overflow, continuous mode, vsync/byte collision and async reset.
`timescale 1ns/1ps
module tb_cam_capture_ctrl;
  localparam int AW    = 15;
  localparam int DW    = 12;
  localparam int IMA_W = 160;
  localparam int IMA_H = 120;
  localparam int W     = AW + DW;
  localparam int NPIX  = IMA_W * IMA_H;

  typedef struct {
    logic          start;
    logic          vsync;
    logic          href;
    logic [7:0]    px;
    logic [2:0]    st;
    logic          rw;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          busy;
    logic          fd;
    logic          lerr;
  } vec_t;

  logic clk = 1'b0;
  logic reset;

  cam_capture_if #(.AW(AW), .DW(DW)) cam ();

  cam_capture_ctrl #(.AW(AW), .DW(DW), .IMA_W(IMA_W), .IMA_H(IMA_H)) dut (
    .clk   (clk),
    .reset (reset),
    .cam   (cam)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int checks   = 0;
  int errors   = 0;
  int wr_count = 0;
  int fd_count = 0;
  int max_addr = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Write monitor: every regwrite pulse must match the head of exp_q
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (cam.frame_done === 1'b1) fd_count++;
    if (cam.regwrite === 1'b1) begin
      wr_count++;
      if (int'(cam.addr_in) > max_addr) max_addr = int'(cam.addr_in);
      check("write_addr_in_window", 32'(int'(cam.addr_in) < NPIX), 32'd1);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: addr %0d data 0x%0h, none expected", cam.addr_in, cam.data_in);
      end else begin
        e = exp_q.pop_front();
        check("write_addr_data", 32'({cam.addr_in, cam.data_in}), 32'(e));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    cam.href    = 1'b1;
    cam.px_data = b;
    tick();
  endtask

  task automatic gap(input int n);
    cam.href = 1'b0;
    repeat (n) tick();
  endtask

  function automatic logic [7:0] pb0(input int p);
    return 8'(p * 3 + 53);
  endfunction

  function automatic logic [7:0] pb1(input int p);
    return 8'(255 - p);
  endfunction

  // One pixel; expected write only inside the image window
  task automatic send_pair(input int line, input int p, input logic [7:0] b0, input logic [7:0] b1);
    logic [AW-1:0] a;
    send_byte(b0);
    if (p < IMA_W && line < IMA_H) begin
      a = AW'(line * IMA_W + p);
      exp_q.push_back({a, b0[3:0], b1});
    end
    send_byte(b1);
  endtask

  task automatic send_line(input int line, input int npairs, input bit abc);
    for (int p = 0; p < npairs; p++) begin
      if (abc) send_pair(line, p, 8'h0A, 8'hBC);
      else     send_pair(line, p, pb0(p), pb1(p));
    end
    gap(2);
  endtask

  task automatic arm();
    cam.start = 1'b1;
    tick();
    cam.start = 1'b0;
    cam.vsync = 1'b1;
    tick();
    tick();
    cam.vsync = 1'b0;
    tick();
  endtask

  task automatic end_frame();
    cam.href  = 1'b0;
    cam.vsync = 1'b1;
    tick();
    tick();
  endtask

  task automatic clear_stats();
    wr_count = 0;
    fd_count = 0;
    max_addr = 0;
  endtask

  // ---------------- stimulus ----------------
  vec_t tbl[9];

  initial begin
    // Arm a frame from IDLE, then first two pixels F3,5A / 01,23.
    tbl[0] = '{1'b1, 1'b0, 1'b0, 8'h00, 3'd1, 1'b0, 15'd19199, 12'hABC, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 1'b0, 8'h00, 3'd2, 1'b0, 15'd19199, 12'hABC, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 1'b1, 1'b0, 8'h00, 3'd2, 1'b0, 15'd19199, 12'hABC, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 1'b0, 1'b0, 8'h00, 3'd3, 1'b0, 15'd19199, 12'hABC, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 1'b0, 1'b0, 8'h00, 3'd3, 1'b0, 15'd19199, 12'hABC, 1'b1, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 1'b0, 1'b1, 8'hF3, 3'd3, 1'b0, 15'd19199, 12'hABC, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 1'b0, 1'b1, 8'h5A, 3'd3, 1'b1, 15'd0,     12'h35A, 1'b1, 1'b0, 1'b0};
    tbl[7] = '{1'b0, 1'b0, 1'b1, 8'h01, 3'd3, 1'b0, 15'd0,     12'h35A, 1'b1, 1'b0, 1'b0};
    tbl[8] = '{1'b0, 1'b0, 1'b1, 8'h23, 3'd3, 1'b1, 15'd1,     12'h123, 1'b1, 1'b0, 1'b0};

    reset       = 1'b1;
    cam.start   = 1'b0;
    cam.cont    = 1'b0;
    cam.vsync   = 1'b0;
    cam.href    = 1'b0;
    cam.px_data = 8'h00;
    tick();
    tick();

    // ---- reset state ----
    check("rst_state",    32'(cam.state_dbg),  32'd0);
    check("rst_regwrite", 32'(cam.regwrite),   32'd0);
    check("rst_addr",     32'(cam.addr_in),    32'd0);
    check("rst_data",     32'(cam.data_in),    32'd0);
    check("rst_busy",     32'(cam.busy),       32'd0);
    check("rst_fd",       32'(cam.frame_done), 32'd0);
    check("rst_line_err", 32'(cam.line_err),   32'd0);
    check("rst_ovf",      32'(cam.ovf),        32'd0);
    reset = 1'b0;
    tick();
    check("idle_no_start", 32'(cam.state_dbg), 32'd0);

    // ---- A: full single frame, pattern 0A,BC ----
    clear_stats();
    arm();
    for (int l = 0; l < IMA_H; l++) send_line(l, IMA_W, 1'b1);
    end_frame();
    check("A_writes",     32'(wr_count),      32'(NPIX));
    check("A_max_addr",   32'(max_addr),      32'(NPIX - 1));
    check("A_frame_done", 32'(fd_count),      32'd1);
    check("A_q_empty",    32'(exp_q.size()),  32'd0);
    check("A_busy",       32'(cam.busy),      32'd0);
    check("A_state",      32'(cam.state_dbg), 32'd0);
    check("A_line_err",   32'(cam.line_err),  32'd0);
    check("A_ovf",        32'(cam.ovf),       32'd0);

    // ---- B: vector table (arming, latency), then 323-byte line ----
    clear_stats();
    for (int i = 0; i < 9; i++) begin
      cam.start   = tbl[i].start;
      cam.vsync   = tbl[i].vsync;
      cam.href    = tbl[i].href;
      cam.px_data = tbl[i].px;
      if (tbl[i].rw) exp_q.push_back({tbl[i].addr, tbl[i].data});
      tick();
      check($sformatf("vec%0d_state", i), 32'(cam.state_dbg),  32'(tbl[i].st));
      check($sformatf("vec%0d_rw", i),    32'(cam.regwrite),   32'(tbl[i].rw));
      check($sformatf("vec%0d_addr", i),  32'(cam.addr_in),    32'(tbl[i].addr));
      check($sformatf("vec%0d_data", i),  32'(cam.data_in),    32'(tbl[i].data));
      check($sformatf("vec%0d_busy", i),  32'(cam.busy),       32'(tbl[i].busy));
      check($sformatf("vec%0d_fd", i),    32'(cam.frame_done), 32'(tbl[i].fd));
      check($sformatf("vec%0d_lerr", i),  32'(cam.line_err),   32'(tbl[i].lerr));
    end
    cam.start = 1'b0;
    for (int p = 2; p <= IMA_W; p++) send_pair(0, p, pb0(p), pb1(p));
    send_byte(8'hEE);
    gap(2);
    check("B_line_err_set", 32'(cam.line_err), 32'd1);
    check("B_ovf_clear",    32'(cam.ovf),      32'd0);
    check("B_line0_writes", 32'(wr_count),     32'(IMA_W));
    send_line(1, IMA_W, 1'b0);
    end_frame();
    check("B_writes",        32'(wr_count),     32'(2 * IMA_W));
    check("B_max_addr",      32'(max_addr),     32'(2 * IMA_W - 1));
    check("B_frame_done",    32'(fd_count),     32'd1);
    check("B_q_empty",       32'(exp_q.size()), 32'd0);
    check("B_lerr_in_idle",  32'(cam.line_err), 32'd1);

    // ---- C: continuous, 121 lines (line 5 short) -> ovf + line_err ----
    clear_stats();
    cam.cont = 1'b1;
    arm();
    check("C_flags_cleared", 32'({cam.line_err, cam.ovf}), 32'd0);
    for (int l = 0; l <= IMA_H; l++) send_line(l, (l == 5) ? IMA_W - 1 : IMA_W, 1'b0);
    check("C_ovf",      32'(cam.ovf),      32'd1);
    check("C_line_err", 32'(cam.line_err), 32'd1);
    check("C_writes",   32'(wr_count),     32'(NPIX - 1));
    check("C_max_addr", 32'(max_addr),     32'(NPIX - 1));
    cam.vsync = 1'b1;
    tick();
    check("C_done_state", 32'(cam.state_dbg),  32'd4);
    check("C_done_pulse", 32'(cam.frame_done), 32'd1);
    tick();
    check("C_cont_state", 32'(cam.state_dbg),  32'd2);
    check("C_cont_busy",  32'(cam.busy),       32'd1);
    check("C_fd_single",  32'(cam.frame_done), 32'd0);
    check("C_ovf_hold",   32'(cam.ovf),        32'd1);
    cam.vsync = 1'b0;
    tick();
    check("D_capture",      32'(cam.state_dbg), 32'd3);
    check("D_ovf_cleared",  32'(cam.ovf),       32'd0);
    check("D_lerr_cleared", 32'(cam.line_err),  32'd0);

    // ---- D: second continuous frame, cont dropped mid-frame ----
    wr_count = 0;
    max_addr = 0;
    send_line(0, IMA_W, 1'b0);
    cam.cont = 1'b0;
    send_line(1, IMA_W, 1'b0);
    send_byte(8'h77);
    cam.vsync   = 1'b1;
    cam.px_data = 8'h88;
    tick();
    check("D_collide_state", 32'(cam.state_dbg), 32'd4);
    check("D_collide_nowr",  32'(cam.regwrite),  32'd0);
    cam.href = 1'b0;
    tick();
    check("D_idle",        32'(cam.state_dbg), 32'd0);
    check("D_busy",        32'(cam.busy),      32'd0);
    check("D_writes",      32'(wr_count),      32'(2 * IMA_W));
    check("D_frame_dones", 32'(fd_count),      32'd2);
    check("D_q_empty",     32'(exp_q.size()),  32'd0);

    // ---- E: async reset mid-line after 50 pixels, then re-arm ----
    clear_stats();
    arm();
    for (int p = 0; p < 49; p++) send_pair(0, p, pb0(p), pb1(p));
    send_byte(pb0(49));
    send_byte(pb1(49));
    check("E_pre_rst_rw",   32'(cam.regwrite), 32'd1);
    check("E_pre_rst_addr", 32'(cam.addr_in),  32'd49);
    #2;
    reset = 1'b1;
    #1;
    check("E_rst_rw",    32'(cam.regwrite),  32'd0);
    check("E_rst_state", 32'(cam.state_dbg), 32'd0);
    check("E_rst_busy",  32'(cam.busy),      32'd0);
    check("E_rst_addr",  32'(cam.addr_in),   32'd0);
    check("E_rst_data",  32'(cam.data_in),   32'd0);
    cam.href  = 1'b0;
    cam.vsync = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    check("E_writes_before", 32'(wr_count), 32'd49);
    clear_stats();
    arm();
    for (int l = 0; l < 3; l++) send_line(l, IMA_W, 1'b1);
    end_frame();
    check("E_writes",     32'(wr_count),     32'(3 * IMA_W));
    check("E_max_addr",   32'(max_addr),     32'(3 * IMA_W - 1));
    check("E_frame_done", 32'(fd_count),     32'd1);
    check("E_q_empty",    32'(exp_q.size()), 32'd0);

    // ---- final report ----
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/cam_capture_ctrl.md
Name: cam_capture_ctrl

Overview:
- Write-side controller for the dual-port frame buffer (AW=15, DW=12, 160x120 RGB444 image).
- Samples the camera byte stream (vsync, href, 8-bit data) on the single system clock and assembles two bytes into one 12-bit pixel.
- Generates the buffer's write address, write data and write enable, and reports frame completion and format errors.
- Buffer address IMA_W*IMA_H (19200) is reserved for black and is never written by this block.

Parameters:
- AW, 15: buffer address width.
- DW, 12: pixel width; fixed RGB444.
- IMA_W, 160: pixels per line.
- IMA_H, 120: lines per frame.

Ports:
- clk  in  1  system clock; camera signals are sampled on its rising edge.
- reset  in  1  asynchronous, active-high.
- start  in  1  level; when 1 in IDLE, arms capture.
- cont  in  1  1 = continuous frames; 0 = single frame.
- vsync  in  1  camera frame sync; high between frames.
- href  in  1  camera line valid.
- px_data  in  8  camera byte.
- addr_in  out  AW  buffer write address.
- data_in  out  DW  buffer write data.
- regwrite  out  1  buffer write enable, one-cycle pulse per pixel.
- frame_done  out  1  one-cycle pulse at end of a captured frame.
- busy  out  1  1 in any state other than IDLE.
- line_err  out  1  sticky: a line ended with a column count other than IMA_W.
- ovf  out  1  sticky: a pixel arrived at or beyond row IMA_H.

Behaviour:
- Reset (async): state=IDLE; all outputs 0; internal col, row, phase and hi-nibble registers 0.
- All outputs are registered.
- States:
  - IDLE: start=1 -> WAIT_VS_HI.
  - WAIT_VS_HI: vsync=1 -> WAIT_VS_LO.
  - WAIT_VS_LO: vsync=0 -> CAPTURE. On entry: col=0, row=0, phase=0; line_err and ovf cleared.
  - CAPTURE: vsync=1 -> DONE.
  - DONE: for exactly one cycle, frame_done=1. Then -> WAIT_VS_LO if cont=1, else IDLE. vsync is already high, so continuous mode skips WAIT_VS_HI.
- start is ignored outside IDLE.
- Deasserting cont mid-frame takes effect at DONE.
- Pixel assembly in CAPTURE with href=1:
  - phase 0: latch px_data[3:0] as the red nibble; phase<=1.
  - phase 1: form pixel {red nibble, px_data[7:0]}; phase<=0.
- Write timing: on the edge sampling the phase-1 byte, regwrite<=1, data_in<=pixel, addr_in<=row*IMA_W+col, and col increments. Latency is 1 cycle from second-byte sample to regwrite high. regwrite is high for that cycle only.
- Write suppression: if col>=IMA_W or row>=IMA_H, regwrite stays 0. In that case:
  - col still increments (saturating at 2^AW-1);
  - ovf<=1 if row>=IMA_H;
  - addr_in and data_in hold their previous values.
- Address arithmetic: row*IMA_W+col computed as an AW-bit value. Implement with a running row_base register (row_base += IMA_W per line) plus col; no multiplier.
- href falling (href=0 after href=1) in CAPTURE:
  - if col!=IMA_W, then line_err<=1;
  - row++, row_base+=IMA_W, col<=0, phase<=0.
  - An odd trailing byte is discarded.
- href=0 cycles between lines: no writes, phase held at 0.
- vsync rising in the same cycle as a phase-1 byte: that byte is dropped, no write, transition to DONE.
- Frame shorter than IMA_H lines: frame_done still pulses. Unwritten addresses keep prior contents. No error flag.
- Reset asserted mid-frame: immediate return to IDLE, regwrite=0 with no partial write. Buffer contents untouched.
- line_err and ovf remain valid through DONE and IDLE until the next WAIT_VS_LO->CAPTURE transition.

Test Plan:
- Single frame, cont=0: start=1, vsync 1->0, 120 lines x 320 bytes with byte pairs 0x0A,0xBC. Required:
  - 19200 regwrite pulses, data_in=12'hABC, addr 0..19199 in order;
  - last address 19199, regwrite never at 19200;
  - one frame_done; busy=0 afterwards; line_err=0, ovf=0.
- Latency/format: bytes 0xF3, 0x5A at cycles n and n+1 -> regwrite=1 at n+2 only, data_in=12'h35A, addr_in=0.
- Long/odd line: line 0 with 323 bytes -> 160 writes (addr 0..159), extra pixel and odd byte dropped, line_err=1. Next line first write at addr 160.
- Overflow: 121 full lines -> no write for line 121, ovf=1, frame_done still pulses, max addr 19199.
- Continuous: cont=1, two frames -> two frame_done pulses. Second frame restarts at addr 0 without passing IDLE; flags cleared at second frame start.
- Async reset mid-line after 50 pixels -> outputs 0 within the same cycle, state IDLE. Re-arm with start captures a full frame from addr 0.
